// File: rtl/difftest_event_pkg.sv
// Shared types for the difftest architectural-event queue.
// Fields sized for the widest supported configuration; narrower instances zero-extend.
package difftest_event_pkg;

  localparam int COREID_W   = 8;
  localparam int INTR_W     = 32;
  localparam int CAUSE_W    = 32;
  localparam int INST_W     = 32;
  localparam int PC_MAX_W   = 64;
  localparam int CHAN_MAX_W = 3;
  localparam int SEQ_MAX_W  = 32;

  typedef struct packed {
    logic [COREID_W-1:0] coreid;
    logic [INTR_W-1:0]   intrNO;
    logic [CAUSE_W-1:0]  cause;
    logic [PC_MAX_W-1:0] exceptionPC;
    logic [INST_W-1:0]   exceptionInst;
  } arch_event_t;

  typedef struct packed {
    arch_event_t           evt;
    logic [CHAN_MAX_W-1:0] chan;
    logic [SEQ_MAX_W-1:0]  seq;
  } queue_entry_t;

  function automatic int chanWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/difftest_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer and wraps; the pointer moves
// past the winner only when a grant is issued.
module difftest_rr_arbiter
  import difftest_event_pkg::*;
#(
  parameter  int NCH = 2,
  localparam int CW  = chanWidth(NCH)
) (
  input  logic           io_clock,
  input  logic           io_reset,
  input  logic [NCH-1:0] req,
  input  logic           enable,
  output logic [NCH-1:0] grantOh,
  output logic [CW-1:0]  grantIdx,
  output logic           grantValid
);

  logic [CW-1:0] ptr;

  always_comb begin
    int idx;
    idx        = 0;
    grantOh    = '0;
    grantIdx   = '0;
    grantValid = 1'b0;
    if (enable) begin
      for (int k = 0; k < NCH; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (!grantValid && req[CW'(idx)]) begin
          grantValid         = 1'b1;
          grantOh[CW'(idx)]  = 1'b1;
          grantIdx           = CW'(idx);
        end
      end
    end
  end

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      ptr <= '0;
    end else if (grantValid) begin
      ptr <= (int'(grantIdx) == NCH - 1) ? '0 : grantIdx + 1'b1;
    end
  end

endmodule

// File: rtl/difftest_arch_event_queue.sv
// Multi-channel arch-event capture: per-channel holding regs, round-robin merge
// into a FIFO, sequence tagging, and a saturating count of dropped events.
module difftest_arch_event_queue
  import difftest_event_pkg::*;
#(
  parameter  int NCH         = 2,
  parameter  int DEPTH       = 8,
  parameter  int PC_W        = 64,
  parameter  int SEQ_W       = 16,
  parameter  int DROP_W      = 16,
  parameter  int FILTER_NULL = 1,
  localparam int CW          = chanWidth(NCH),
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                    io_clock,
  input  logic                    io_reset,
  input  logic [NCH-1:0]          io_in_valid,
  input  logic [COREID_W*NCH-1:0] io_in_coreid,
  input  logic [INTR_W*NCH-1:0]   io_in_intrNO,
  input  logic [CAUSE_W*NCH-1:0]  io_in_cause,
  input  logic [PC_W*NCH-1:0]     io_in_exceptionPC,
  input  logic [INST_W*NCH-1:0]   io_in_exceptionInst,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic [COREID_W-1:0]     io_out_coreid,
  output logic [INTR_W-1:0]       io_out_intrNO,
  output logic [CAUSE_W-1:0]      io_out_cause,
  output logic [PC_W-1:0]         io_out_exceptionPC,
  output logic [INST_W-1:0]       io_out_exceptionInst,
  output logic [CW-1:0]           io_out_chan,
  output logic [SEQ_W-1:0]        io_out_seq,
  output logic [AW:0]             io_count,
  output logic [DROP_W-1:0]       io_drop_cnt
);

  arch_event_t  inEvt [NCH];
  arch_event_t  hEvt  [NCH];
  logic [NCH-1:0] hValid, qual, load, drop, grantOh;
  logic [CW-1:0]  grantIdx;
  logic           grantValid, canPush, pop, full, empty;
  logic [3:0]     dropSum;
  logic [DROP_W:0] dropNext;
  logic [DROP_W-1:0] dropCnt;
  logic [SEQ_W-1:0]  seqCnt;
  logic [AW:0]       wrPtr, rdPtr;
  queue_entry_t      mem [DEPTH];
  queue_entry_t      pushEntry, head;
  logic              unusedHeadBits;

  // A holding reg being drained this cycle can accept a new event in the same cycle.
  always_comb begin
    dropSum = '0;
    for (int i = 0; i < NCH; i++) begin
      inEvt[i].coreid        = io_in_coreid[i*COREID_W +: COREID_W];
      inEvt[i].intrNO        = io_in_intrNO[i*INTR_W +: INTR_W];
      inEvt[i].cause         = io_in_cause[i*CAUSE_W +: CAUSE_W];
      inEvt[i].exceptionPC   = PC_MAX_W'(io_in_exceptionPC[i*PC_W +: PC_W]);
      inEvt[i].exceptionInst = io_in_exceptionInst[i*INST_W +: INST_W];
      qual[i] = io_in_valid[i] &
                ~((FILTER_NULL != 0) && (inEvt[i].intrNO == '0) && (inEvt[i].cause == '0));
      load[i] = qual[i] & (~hValid[i] | grantOh[i]);
      drop[i] = qual[i] & ~load[i];
      dropSum = dropSum + 4'(drop[i]);
    end
  end

  assign dropNext = {1'b0, dropCnt} + (DROP_W+1)'(dropSum);

  assign empty   = (wrPtr == rdPtr);
  assign full    = (io_count == (AW+1)'(DEPTH));
  assign pop     = ~empty & io_out_ready;
  assign canPush = ~full | pop;

  difftest_rr_arbiter #(.NCH(NCH)) u_arb (
    .io_clock   (io_clock),
    .io_reset   (io_reset),
    .req        (hValid),
    .enable     (canPush),
    .grantOh    (grantOh),
    .grantIdx   (grantIdx),
    .grantValid (grantValid)
  );

  always_comb begin
    pushEntry      = '0;
    pushEntry.evt  = hEvt[grantIdx];
    pushEntry.chan = CHAN_MAX_W'(grantIdx);
    pushEntry.seq  = SEQ_MAX_W'(seqCnt);
  end

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      hValid  <= '0;
      dropCnt <= '0;
      seqCnt  <= '0;
      wrPtr   <= '0;
      rdPtr   <= '0;
    end else begin
      hValid  <= (hValid & ~grantOh) | load;
      dropCnt <= dropNext[DROP_W] ? '1 : dropNext[DROP_W-1:0];
      if (grantValid) begin
        seqCnt <= seqCnt + 1'b1;
        wrPtr  <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Payload storage carries no reset; validity lives entirely in the pointers.
  always_ff @(posedge io_clock) begin
    for (int i = 0; i < NCH; i++) begin
      if (load[i]) hEvt[i] <= inEvt[i];
    end
    if (grantValid) mem[wrPtr[AW-1:0]] <= pushEntry;
  end

  assign head           = mem[rdPtr[AW-1:0]];
  assign unusedHeadBits = ^{head.chan, head.seq, head.evt.exceptionPC};

  assign io_out_valid         = ~empty;
  assign io_out_coreid        = empty ? '0 : head.evt.coreid;
  assign io_out_intrNO        = empty ? '0 : head.evt.intrNO;
  assign io_out_cause         = empty ? '0 : head.evt.cause;
  assign io_out_exceptionPC   = empty ? '0 : head.evt.exceptionPC[PC_W-1:0];
  assign io_out_exceptionInst = empty ? '0 : head.evt.exceptionInst;
  assign io_out_chan          = empty ? '0 : head.chan[CW-1:0];
  assign io_out_seq           = empty ? '0 : head.seq[SEQ_W-1:0];
  assign io_count             = wrPtr - rdPtr;
  assign io_drop_cnt          = dropCnt;

endmodule

// File: tb/tb_difftest_arch_event_queue.sv
// Directed bench for difftest_arch_event_queue at NCH=2, DEPTH=8, PC_W=64, SEQ_W=16, DROP_W=16.
module tb_difftest_arch_event_queue;

  logic         io_clock = 1'b0;
  logic         io_reset;
  logic [1:0]   io_in_valid;
  logic [15:0]  io_in_coreid;
  logic [63:0]  io_in_intrNO, io_in_cause, io_in_exceptionInst;
  logic [127:0] io_in_exceptionPC;
  logic         io_out_valid, io_out_ready;
  logic [7:0]   io_out_coreid;
  logic [31:0]  io_out_intrNO, io_out_cause, io_out_exceptionInst;
  logic [63:0]  io_out_exceptionPC;
  logic [0:0]   io_out_chan;
  logic [15:0]  io_out_seq;
  logic [3:0]   io_count;
  logic [15:0]  io_drop_cnt;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 io_clock = ~io_clock;

  difftest_arch_event_queue #(
    .NCH(2), .DEPTH(8), .PC_W(64), .SEQ_W(16), .DROP_W(16), .FILTER_NULL(1)
  ) dut (
    .io_clock(io_clock), .io_reset(io_reset),
    .io_in_valid(io_in_valid), .io_in_coreid(io_in_coreid),
    .io_in_intrNO(io_in_intrNO), .io_in_cause(io_in_cause),
    .io_in_exceptionPC(io_in_exceptionPC), .io_in_exceptionInst(io_in_exceptionInst),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_coreid(io_out_coreid), .io_out_intrNO(io_out_intrNO),
    .io_out_cause(io_out_cause), .io_out_exceptionPC(io_out_exceptionPC),
    .io_out_exceptionInst(io_out_exceptionInst), .io_out_chan(io_out_chan),
    .io_out_seq(io_out_seq), .io_count(io_count), .io_drop_cnt(io_drop_cnt)
  );

  task automatic tick();
    @(posedge io_clock);
    #1;
  endtask

  task automatic clearIn();
    io_in_valid = '0; io_in_coreid = '0; io_in_intrNO = '0; io_in_cause = '0;
    io_in_exceptionPC = '0; io_in_exceptionInst = '0;
  endtask

  task automatic setCh(input int ch, input logic [7:0] core, input logic [31:0] intr,
                       input logic [31:0] cause, input logic [63:0] pc, input logic [31:0] inst);
    io_in_valid[ch] = 1'b1;
    io_in_coreid[ch*8 +: 8] = core;
    io_in_intrNO[ch*32 +: 32] = intr;
    io_in_cause[ch*32 +: 32] = cause;
    io_in_exceptionPC[ch*64 +: 64] = pc;
    io_in_exceptionInst[ch*32 +: 32] = inst;
  endtask

  task automatic doReset();
    clearIn();
    io_out_ready = 1'b0;
    io_reset = 1'b1;
    tick(); tick();
    io_reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    nCompared++; if (io_out_valid !== 1'b0) begin nMismatched++; $display("FAIL reset_valid: got %0b want 0", io_out_valid); end
    nCompared++; if (io_count !== 4'd0) begin nMismatched++; $display("FAIL reset_count: got %0d want 0", io_count); end
    nCompared++; if (io_drop_cnt !== 16'd0) begin nMismatched++; $display("FAIL reset_drop: got %0d want 0", io_drop_cnt); end
    nCompared++; if ({io_out_coreid, io_out_intrNO, io_out_cause, io_out_exceptionPC, io_out_exceptionInst, io_out_chan, io_out_seq} !== '0)
      begin nMismatched++; $display("FAIL reset_fields: got intr=%h cause=%h pc=%h seq=%h want all 0", io_out_intrNO, io_out_cause, io_out_exceptionPC, io_out_seq); end
  endtask

  task automatic test_single();
    doReset();
    io_out_ready = 1'b1;
    setCh(0, 8'd3, 32'd7, 32'd0, 64'h8000_1000, 32'h0000_0013);
    tick();
    clearIn();
    nCompared++; if (io_out_valid !== 1'b0) begin nMismatched++; $display("FAIL single_t1_valid: got %0b want 0", io_out_valid); end
    tick();
    nCompared++; if (io_out_valid !== 1'b1) begin nMismatched++; $display("FAIL single_t2_valid: got %0b want 1", io_out_valid); end
    nCompared++; if (io_out_intrNO !== 32'd7 || io_out_chan !== 1'b0 || io_out_seq !== 16'd0)
      begin nMismatched++; $display("FAIL single_head: got intr=%0d chan=%0d seq=%0d want 7/0/0", io_out_intrNO, io_out_chan, io_out_seq); end
    nCompared++; if (io_out_exceptionPC !== 64'h8000_1000 || io_out_coreid !== 8'd3 || io_out_exceptionInst !== 32'h13)
      begin nMismatched++; $display("FAIL single_payload: got pc=%h core=%0d inst=%h want 80001000/3/13", io_out_exceptionPC, io_out_coreid, io_out_exceptionInst); end
    tick();
    nCompared++; if (io_count !== 4'd0 || io_out_valid !== 1'b0)
      begin nMismatched++; $display("FAIL single_drain: got count=%0d valid=%0b want 0/0", io_count, io_out_valid); end
  endtask

  task automatic test_both();
    doReset();
    io_out_ready = 1'b1;
    setCh(0, 8'd0, 32'd0, 32'd2, 64'h100, 32'd0);
    setCh(1, 8'd1, 32'd0, 32'd5, 64'h200, 32'd0);
    tick();
    clearIn();
    tick();
    nCompared++; if (io_out_valid !== 1'b1 || io_out_chan !== 1'b0 || io_out_cause !== 32'd2 || io_out_seq !== 16'd0)
      begin nMismatched++; $display("FAIL both_first: got v=%0b chan=%0d cause=%0d seq=%0d want 1/0/2/0", io_out_valid, io_out_chan, io_out_cause, io_out_seq); end
    tick();
    nCompared++; if (io_out_valid !== 1'b1 || io_out_chan !== 1'b1 || io_out_cause !== 32'd5 || io_out_seq !== 16'd1)
      begin nMismatched++; $display("FAIL both_second: got v=%0b chan=%0d cause=%0d seq=%0d want 1/1/5/1", io_out_valid, io_out_chan, io_out_cause, io_out_seq); end
    tick();
    nCompared++; if (io_out_valid !== 1'b0) begin nMismatched++; $display("FAIL both_empty: got %0b want 0", io_out_valid); end
  endtask

  // ch0 wins first, moving the pointer to ch1, so ch1 beats the reloaded ch0 next.
  task automatic test_round_robin();
    doReset();
    io_out_ready = 1'b1;
    setCh(0, 8'd0, 32'd0, 32'd9, 64'h0, 32'd0);
    tick();
    clearIn();
    setCh(0, 8'd0, 32'd0, 32'd2, 64'h0, 32'd0);
    setCh(1, 8'd0, 32'd0, 32'd5, 64'h0, 32'd0);
    tick();
    clearIn();
    nCompared++; if (io_out_chan !== 1'b0 || io_out_cause !== 32'd9 || io_out_seq !== 16'd0)
      begin nMismatched++; $display("FAIL rr_0: got chan=%0d cause=%0d seq=%0d want 0/9/0", io_out_chan, io_out_cause, io_out_seq); end
    tick();
    nCompared++; if (io_out_chan !== 1'b1 || io_out_cause !== 32'd5 || io_out_seq !== 16'd1)
      begin nMismatched++; $display("FAIL rr_1: got chan=%0d cause=%0d seq=%0d want 1/5/1", io_out_chan, io_out_cause, io_out_seq); end
    tick();
    nCompared++; if (io_out_chan !== 1'b0 || io_out_cause !== 32'd2 || io_out_seq !== 16'd2)
      begin nMismatched++; $display("FAIL rr_2: got chan=%0d cause=%0d seq=%0d want 0/2/2", io_out_chan, io_out_cause, io_out_seq); end
  endtask

  task automatic test_backpressure();
    doReset();
    for (int k = 0; k < 12; k++) begin
      setCh(0, 8'd0, 32'(k + 1), 32'd0, 64'h40, 32'd0);
      tick();
      if (k == 6) begin
        nCompared++; if (io_out_intrNO !== 32'd1 || io_out_seq !== 16'd0)
          begin nMismatched++; $display("FAIL bp_stable_mid: got intr=%0d seq=%0d want 1/0", io_out_intrNO, io_out_seq); end
      end
    end
    clearIn();
    nCompared++; if (io_count !== 4'd8) begin nMismatched++; $display("FAIL bp_count_full: got %0d want 8", io_count); end
    nCompared++; if (io_drop_cnt !== 16'd3) begin nMismatched++; $display("FAIL bp_drops: got %0d want 3", io_drop_cnt); end
    nCompared++; if (io_out_valid !== 1'b1 || io_out_intrNO !== 32'd1 || io_out_seq !== 16'd0)
      begin nMismatched++; $display("FAIL bp_stable_end: got v=%0b intr=%0d seq=%0d want 1/1/0", io_out_valid, io_out_intrNO, io_out_seq); end
    io_out_ready = 1'b1;
    for (int n = 0; n < 9; n++) begin
      nCompared++; if (io_out_valid !== 1'b1 || io_out_seq !== 16'(n) || io_out_intrNO !== 32'(n + 1))
        begin nMismatched++; $display("FAIL bp_drain_%0d: got v=%0b seq=%0d intr=%0d want 1/%0d/%0d", n, io_out_valid, io_out_seq, io_out_intrNO, n, n + 1); end
      tick();
      if (n == 0) begin
        nCompared++; if (io_count !== 4'd8) begin nMismatched++; $display("FAIL bp_full_pop_push: got %0d want 8", io_count); end
      end
    end
    nCompared++; if (io_out_valid !== 1'b0 || io_count !== 4'd0 || io_drop_cnt !== 16'd3)
      begin nMismatched++; $display("FAIL bp_after: got v=%0b count=%0d drop=%0d want 0/0/3", io_out_valid, io_count, io_drop_cnt); end
  endtask

  task automatic test_filter();
    doReset();
    io_out_ready = 1'b1;
    setCh(0, 8'd0, 32'd0, 32'd0, 64'h1234, 32'd0);
    setCh(1, 8'd0, 32'd0, 32'd0, 64'h5678, 32'd0);
    tick(); tick();
    clearIn();
    tick();
    nCompared++; if (io_out_valid !== 1'b0 || io_count !== 4'd0 || io_drop_cnt !== 16'd0)
      begin nMismatched++; $display("FAIL filter_null: got v=%0b count=%0d drop=%0d want 0/0/0", io_out_valid, io_count, io_drop_cnt); end
    setCh(0, 8'd0, 32'd0, 32'd1, 64'h1234, 32'd0);
    tick();
    clearIn();
    tick();
    nCompared++; if (io_out_valid !== 1'b1 || io_out_cause !== 32'd1 || io_out_seq !== 16'd0)
      begin nMismatched++; $display("FAIL filter_pass: got v=%0b cause=%0d seq=%0d want 1/1/0", io_out_valid, io_out_cause, io_out_seq); end
  endtask

  task automatic test_mid_reset();
    doReset();
    for (int k = 0; k < 6; k++) begin
      setCh(0, 8'd0, 32'd0, 32'(k + 1), 64'h0, 32'd0);
      tick();
    end
    clearIn();
    nCompared++; if (io_count !== 4'd5) begin nMismatched++; $display("FAIL midrst_pre: got %0d want 5", io_count); end
    io_reset = 1'b1;
    tick();
    io_reset = 1'b0;
    nCompared++; if (io_out_valid !== 1'b0 || io_count !== 4'd0 || io_drop_cnt !== 16'd0)
      begin nMismatched++; $display("FAIL midrst_cleared: got v=%0b count=%0d drop=%0d want 0/0/0", io_out_valid, io_count, io_drop_cnt); end
    io_out_ready = 1'b1;
    setCh(0, 8'd0, 32'd0, 32'd99, 64'h0, 32'd0);
    tick();
    clearIn();
    tick();
    nCompared++; if (io_out_valid !== 1'b1 || io_out_seq !== 16'd0 || io_out_cause !== 32'd99)
      begin nMismatched++; $display("FAIL midrst_next: got v=%0b seq=%0d cause=%0d want 1/0/99", io_out_valid, io_out_seq, io_out_cause); end
  endtask

  // Both channels strobed every cycle: one push and one drop per cycle in steady state.
  task automatic test_seq_wrap_drop_sat();
    int outCnt, seqErr;
    logic [15:0] sHi, sLo;
    outCnt = 0; seqErr = 0; sHi = 16'h0; sLo = 16'h1234;
    doReset();
    io_out_ready = 1'b1;
    for (int i = 0; i < 65610; i++) begin
      if (i < 65600) begin
        setCh(0, 8'd0, 32'd0, 32'd1, 64'h0, 32'd0);
        setCh(1, 8'd0, 32'd0, 32'd2, 64'h0, 32'd0);
      end else begin
        clearIn();
      end
      if (io_out_valid === 1'b1) begin
        if (io_out_seq !== 16'(outCnt)) seqErr++;
        if (outCnt == 65535) sHi = io_out_seq;
        if (outCnt == 65536) sLo = io_out_seq;
        outCnt++;
      end
      tick();
    end
    nCompared++; if (seqErr !== 0) begin nMismatched++; $display("FAIL wrap_seq_stream: got %0d bad seqs want 0", seqErr); end
    nCompared++; if (sHi !== 16'hFFFF || sLo !== 16'h0000)
      begin nMismatched++; $display("FAIL wrap_seq: got %h then %h want ffff then 0000", sHi, sLo); end
    nCompared++; if (outCnt < 65537) begin nMismatched++; $display("FAIL wrap_outputs: got %0d want >=65537", outCnt); end
    nCompared++; if (io_drop_cnt !== 16'hFFFF) begin nMismatched++; $display("FAIL drop_saturate: got %h want ffff", io_drop_cnt); end
    nCompared++; if (io_count !== 4'd0) begin nMismatched++; $display("FAIL wrap_drained: got %0d want 0", io_count); end
  endtask

  initial begin
    clearIn();
    io_out_ready = 1'b0;
    io_reset = 1'b1;
    test_reset();
    test_single();
    test_both();
    test_round_robin();
    test_backpressure();
    test_filter();
    test_mid_reset();
    test_seq_wrap_drop_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
